// File: rtl/lfsr_sequence_checker.sv
// Receive-side PRBS checker: self-synchronises to a Fibonacci LFSR word stream,
// flywheels the predictor once locked, and counts checked and mismatched words.
module lfsr_sequence_checker #(
  parameter int unsigned LENGTH       = 16,
  parameter int unsigned TAPS         = 53256,
  parameter int unsigned LOCK_COUNT   = 8,
  parameter int unsigned UNLOCK_COUNT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LENGTH-1:0] data_in_i,
  input  logic              data_valid_i,
  input  logic              clear_i,
  output logic              locked_o,
  output logic              err_pulse_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [CNT_W-1:0]  word_count_o
);

  localparam logic [LENGTH-1:0] TAP_MASK = LENGTH'(TAPS);
  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned UW = $clog2(UNLOCK_COUNT + 1);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_SYNC     = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  // Same recurrence as the generator: feedback is the tap parity folded with the LSB.
  function automatic logic [LENGTH-1:0] lfsr_next(input logic [LENGTH-1:0] w);
    return {(^(w & TAP_MASK)) ^ w[0], w[LENGTH-1:1]};
  endfunction

  logic [1:0]        state_q, state_d;
  logic [LENGTH-1:0] pred_q, pred_d;
  logic [MW-1:0]     match_q, match_d;
  logic [UW-1:0]     miss_q, miss_d;
  logic              err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;
  logic              err_inc, word_inc;
  logic              word_ok, word_zero;

  assign word_ok   = (data_in_i == pred_q);
  assign word_zero = (data_in_i == '0);

  always_comb begin
    state_d     = state_q;
    pred_d      = pred_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_pulse_d = 1'b0;
    err_inc     = 1'b0;
    word_inc    = 1'b0;
    if (data_valid_i) begin
      case (state_q)
        ST_UNLOCKED: begin
          // The all-zero word is the LFSR lock-up state and can never seed a valid stream.
          if (!word_zero) begin
            pred_d  = lfsr_next(data_in_i);
            match_d = '0;
            state_d = ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (word_ok) begin
            pred_d = lfsr_next(data_in_i);
            if (match_q == MW'(LOCK_COUNT - 1)) begin
              match_d = MW'(LOCK_COUNT);
              miss_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else if (!word_zero) begin
            pred_d  = lfsr_next(data_in_i);
            match_d = '0;
          end else begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED: begin
          // Flywheel: a corrupted input word must not disturb the predictor.
          pred_d   = lfsr_next(pred_q);
          word_inc = 1'b1;
          if (word_ok) begin
            miss_d = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            miss_d      = miss_q + 1'b1;
            if (miss_q == UW'(UNLOCK_COUNT - 1)) begin
              state_d = ST_UNLOCKED;
            end
          end
        end
        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  // Saturating counters; clear wins over a coincident increment.
  always_comb begin
    err_count_d  = err_count_q;
    word_count_d = word_count_q;
    if (clear_i) begin
      err_count_d  = '0;
      word_count_d = '0;
    end else begin
      if (err_inc && (err_count_q != '1)) begin
        err_count_d = err_count_q + 1'b1;
      end
      if (word_inc && (word_count_q != '1)) begin
        word_count_d = word_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_UNLOCKED;
      pred_q       <= '0;
      match_q      <= '0;
      miss_q       <= '0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      match_q      <= match_d;
      miss_q       <= miss_d;
      err_pulse_q  <= err_pulse_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign locked_o     = (state_q == ST_LOCKED);
  assign err_pulse_o  = err_pulse_q;
  assign err_count_o  = err_count_q;
  assign word_count_o = word_count_q;

endmodule

// File: tb/tb_lfsr_sequence_checker.sv
// Bench for lfsr_sequence_checker: directed and randomised word streams checked
// against a word-level behavioural model, on a 16-bit and a 4-bit counter instance.
module tb_lfsr_sequence_checker;

  localparam int LEN   = 16;
  localparam int LOCKN = 8;
  localparam int UNLKN = 4;

  logic           clk;
  logic           rst_n;
  logic [LEN-1:0] din;
  logic           valid;
  logic           clr;
  logic           locked16, pulse16, locked4, pulse4;
  logic [15:0]    err16, words16;
  logic [3:0]     err4, words4;

  lfsr_sequence_checker #(.LENGTH(16), .TAPS(53256), .LOCK_COUNT(8), .UNLOCK_COUNT(4), .CNT_W(16)) u_dut16 (
    .clk_i(clk), .rst_ni(rst_n), .data_in_i(din), .data_valid_i(valid), .clear_i(clr),
    .locked_o(locked16), .err_pulse_o(pulse16), .err_count_o(err16), .word_count_o(words16)
  );

  lfsr_sequence_checker #(.LENGTH(16), .TAPS(53256), .LOCK_COUNT(8), .UNLOCK_COUNT(4), .CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .data_in_i(din), .data_valid_i(valid), .clear_i(clr),
    .locked_o(locked4), .err_pulse_o(pulse4), .err_count_o(err4), .word_count_o(words4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: phase 0 = hunting, 1 = confirming, 2 = locked.
  int          m_phase;
  logic [15:0] m_expect;
  int          m_hits, m_misses;
  int          m_errs, m_words;
  bit          m_pulse;
  logic [15:0] gen;

  function automatic logic [15:0] nxt(input logic [15:0] w);
    logic [15:0] taps;
    taps = 16'hD008;
    return {(^(taps & w)) ^ w[0], w[15:1]};
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_expect = '0; m_hits = 0; m_misses = 0;
    m_errs = 0; m_words = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit v, input logic [15:0] d, input bit c);
    m_pulse = 0;
    if (v) begin
      if (m_phase == 0) begin
        if (d != 0) begin m_expect = nxt(d); m_hits = 0; m_phase = 1; end
      end else if (m_phase == 1) begin
        if (d == m_expect) begin
          m_expect = nxt(d);
          m_hits++;
          if (m_hits == LOCKN) begin m_phase = 2; m_misses = 0; end
        end else if (d != 0) begin
          m_expect = nxt(d); m_hits = 0;
        end else begin
          m_phase = 0;
        end
      end else begin
        m_words++;
        if (d != m_expect) begin
          m_pulse = 1; m_errs++; m_misses++;
          if (m_misses == UNLKN) m_phase = 0;
        end else begin
          m_misses = 0;
        end
        m_expect = nxt(m_expect);
      end
    end
    if (c) begin m_errs = 0; m_words = 0; end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".locked16"}, {31'd0, locked16}, {31'd0, m_phase == 2});
    check({tag, ".pulse16"},  {31'd0, pulse16},  {31'd0, m_pulse});
    check({tag, ".err16"},    {16'd0, err16},    sat(m_errs, 16));
    check({tag, ".words16"},  {16'd0, words16},  sat(m_words, 16));
    check({tag, ".locked4"},  {31'd0, locked4},  {31'd0, m_phase == 2});
    check({tag, ".pulse4"},   {31'd0, pulse4},   {31'd0, m_pulse});
    check({tag, ".err4"},     {28'd0, err4},     sat(m_errs, 4));
    check({tag, ".words4"},   {28'd0, words4},   sat(m_words, 4));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit after the next.
  task automatic cycle(input string tag, input bit v, input logic [15:0] d, input bit c);
    valid = v; din = d; clr = c;
    @(posedge clk); #1;
    model_step(v, d, c);
    $display("%0t %s valid=%0d data=%04h clear=%0d locked=%0d pulse=%0d err=%0d words=%0d",
             $time, tag, v, d, c, locked16, pulse16, err16, words16);
    check_all(tag);
  endtask

  task automatic send(input string tag, input logic [15:0] mask, input bit c);
    cycle(tag, 1'b1, gen ^ mask, c);
    gen = nxt(gen);
  endtask

  int vcount, first_lock;

  initial begin
    rst_n = 1'b0; valid = 1'b0; din = '0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // All-zero words never seed the checker.
    for (int i = 0; i < 6; i++) cycle("zeros", 1'b1, 16'h0000, 1'b0);

    // Clean stream from 0xACE1 locks on the ninth word.
    gen = 16'hACE1;
    for (int i = 1; i <= 12; i++) begin
      send("clean", 16'h0000, 1'b0);
      if (i == 8) check("lock_after_8", {31'd0, locked16}, 32'd0);
      if (i == 9) check("lock_after_9", {31'd0, locked16}, 32'd1);
    end

    // One flipped bit: single pulse, flywheel keeps following words clean.
    send("flip3", 16'h0008, 1'b0);
    check("flip_err_count", {16'd0, err16}, 32'd1);
    for (int i = 0; i < 5; i++) send("post_flip", 16'h0000, 1'b0);
    check("flip_still_locked", {31'd0, locked16}, 32'd1);

    // Four consecutive bad words force resync; relock nine valid words later.
    for (int i = 0; i < 4; i++) send("burst", 16'(1 << i), 1'b0);
    check("burst_err_count", {16'd0, err16}, 32'd5);
    check("burst_unlocked", {31'd0, locked16}, 32'd0);
    for (int i = 1; i <= 9; i++) begin
      send("relock", 16'h0000, 1'b0);
      if (i == 8) check("relock_after_8", {31'd0, locked16}, 32'd0);
    end
    check("relock_after_9", {31'd0, locked16}, 32'd1);

    // Saturation: 20 errors spaced by good words, then clear coinciding with an error.
    send("pre_clear", 16'h0000, 1'b1);
    for (int i = 0; i < 20; i++) begin
      send("sat_bad", 16'h0100, 1'b0);
      send("sat_good", 16'h0000, 1'b0);
    end
    check("sat_err4", {28'd0, err4}, 32'd15);
    check("sat_err16", {16'd0, err16}, 32'd20);
    send("clear_on_err", 16'h0100, 1'b1);
    check("clear_err4", {28'd0, err4}, 32'd0);
    check("clear_pulse", {31'd0, pulse4}, 32'd1);

    // Asynchronous reset mid-cycle while locked.
    for (int i = 0; i < 3; i++) send("pre_rst", 16'h0000, 1'b0);
    valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_locked", {31'd0, locked16}, 32'd0);
    check("async_words", {16'd0, words16}, 32'd0);
    check_all("async_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Random 50% valid duty; errors and clears only once locked.
    gen = 16'hACE1;
    vcount = 0; first_lock = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(1) == 1) begin
        logic [15:0] mask;
        bit c;
        mask = '0;
        c = 1'b0;
        if (m_phase == 2 && $urandom_range(9) == 0) mask = 16'($urandom_range(16'hFFFF, 1));
        if (m_phase == 2 && $urandom_range(29) == 0) c = 1'b1;
        send("rand", mask, c);
        vcount++;
        if (first_lock == 0 && locked16) first_lock = vcount;
      end else begin
        cycle("stall", 1'b0, 16'($urandom), 1'b0);
      end
    end
    check("rand_first_lock", first_lock, 32'd9);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
